// File: rtl/regfile_dump_streamer.sv
// Streams a debug frame on request: a cycle timestamp, every architectural register
// read through the debug port, then an XOR checksum, over a valid/ready interface.
module regfile_dump_streamer #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] dbg_rd_addr,
  input  logic [DATA_WIDTH-1:0] dbg_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);

  typedef enum logic [2:0] {
    IDLE,
    SEND_TS,
    FETCH,
    SEND_REG,
    SEND_CK,
    DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

  state_t                state;
  state_t                next_state;
  logic [DATA_WIDTH-1:0] cycle_cnt;
  logic [DATA_WIDTH-1:0] checksum;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  xfer;

  assign xfer        = out_valid & out_ready;
  assign dbg_rd_addr = idx;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (start) next_state = SEND_TS;
      SEND_TS:  if (xfer) next_state = FETCH;
      FETCH:    next_state = SEND_REG;
      SEND_REG: if (xfer) next_state = (idx == LAST_IDX) ? SEND_CK : FETCH;
      SEND_CK:  if (xfer) next_state = DONE;
      DONE:     next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Handshake outputs decode the registered state only, so nothing from
  // out_ready or dbg_rd_data reaches them combinationally.
  always_comb begin
    busy      = (state != IDLE);
    done      = (state == DONE);
    out_valid = (state == SEND_TS) || (state == SEND_REG) || (state == SEND_CK);
    out_last  = (state == SEND_CK);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cycle_cnt <= '0;
      out_data  <= '0;
      checksum  <= '0;
      idx       <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + DATA_WIDTH'(1);
      case (state)
        IDLE: begin
          if (start) begin
            out_data <= cycle_cnt;
            checksum <= cycle_cnt;
            idx      <= '0;
          end
        end
        FETCH: begin
          out_data <= dbg_rd_data;
          checksum <= checksum ^ dbg_rd_data;
        end
        SEND_REG: begin
          if (xfer) begin
            if (idx == LAST_IDX) begin
              out_data <= checksum;
            end else begin
              idx <= idx + ADDR_WIDTH'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
